// File: rtl/regfile_write_arbiter_if.sv
// Requester-side write bus for regfile_write_arbiter: per-requester valid/addr/data in, one-hot ready out.
// Requester i occupies REQ_ADDR[i*addr_width +: addr_width] and REQ_DATA[i*data_width +: data_width].
interface regfile_write_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int addr_width = 5,
    parameter int data_width = 32
);
    logic [NREQ-1:0]            REQ_VALID;
    logic [NREQ*addr_width-1:0] REQ_ADDR;
    logic [NREQ*data_width-1:0] REQ_DATA;
    logic [NREQ-1:0]            REQ_READY;

    modport master (
        output REQ_VALID,
        output REQ_ADDR,
        output REQ_DATA,
        input  REQ_READY
    );

    modport slave (
        input  REQ_VALID,
        input  REQ_ADDR,
        input  REQ_DATA,
        output REQ_READY
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: sweeps regfile entries lo..hi to INIT_VALUE after reset, then round-robin shares its single write port.
// Latency: accepted request appears on WE/ADDR_IN/D_IN one cycle later (registered outputs).
// Backpressure: one-hot REQ_READY, combinational from REQ_VALID; zero during the sweep. Macro REGFILE_WARB_RANGE_CHECK_EN drops out-of-range writes with ERR.
module regfile_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int lo         = 0,
    parameter int hi         = 31,
    parameter logic [data_width-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    regfile_write_arbiter_if.slave req,
    output logic                  WE,
    output logic [addr_width-1:0] ADDR_IN,
    output logic [data_width-1:0] D_IN,
    output logic [NREQ-1:0]       GRANT,
    output logic                  INIT_DONE,
    output logic                  ERR
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state;
    logic [PTR_W-1:0]      ptr;
    logic [addr_width-1:0] init_cnt;
    logic                  err_q;

    logic [PTR_W-1:0]      rr_idx;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_vld;
    logic [NREQ-1:0]       win_onehot;
    logic [addr_width-1:0] win_addr;
    logic [data_width-1:0] win_data;
    logic [PTR_W-1:0]      ptr_nxt;
    logic                  range_err;

    // Scan from the farthest rotated slot back to ptr so the nearest valid requester is written last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        rr_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr_idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (req.REQ_VALID[rr_idx]) begin
                win_vld = 1'b1;
                win_idx = rr_idx;
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign win_addr = req.REQ_ADDR[int'(win_idx)*addr_width +: addr_width];
    assign win_data = req.REQ_DATA[int'(win_idx)*data_width +: data_width];
    assign ptr_nxt  = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;

    assign req.REQ_READY = (state == ST_RUN && win_vld) ? win_onehot : '0;

`ifdef REGFILE_WARB_RANGE_CHECK_EN
    logic addr_ok;
    assign addr_ok   = (int'(win_addr) >= lo) && (int'(win_addr) <= hi);
    assign range_err = win_vld & ~addr_ok;
`else
    assign range_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_INIT;
            ptr       <= '0;
            init_cnt  <= addr_width'(lo);
            WE        <= 1'b0;
            ADDR_IN   <= '0;
            D_IN      <= '0;
            GRANT     <= '0;
            INIT_DONE <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    WE      <= 1'b1;
                    ADDR_IN <= init_cnt;
                    D_IN    <= INIT_VALUE;
                    GRANT   <= '0;
                    err_q   <= 1'b0;
                    // Test before incrementing so a sweep ending at the top of the address space never wraps.
                    if (init_cnt == addr_width'(hi)) begin
                        state     <= ST_RUN;
                        INIT_DONE <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    WE    <= 1'b0;
                    GRANT <= '0;
                    err_q <= 1'b0;
                    if (win_vld) begin
                        ptr <= ptr_nxt;
                        if (range_err) begin
                            err_q <= 1'b1;
                        end else begin
                            WE      <= 1'b1;
                            ADDR_IN <= win_addr;
                            D_IN    <= win_data;
                            GRANT   <= win_onehot;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign ERR = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: driver pushes expected regfile writes into a queue from a round-robin reference model,
// a monitor pops and compares whenever the DUT writes; covers reset, init sweep, directed arbitration cases and random traffic.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int LO   = 1;
    localparam int HI   = 31;
    localparam logic [DW-1:0] INITV = 32'hDEAD_BEEF;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            WE;
    logic [AW-1:0]   ADDR_IN;
    logic [DW-1:0]   D_IN;
    logic [NREQ-1:0] GRANT;
    logic            INIT_DONE;
    logic            ERR;

    regfile_write_arbiter_if #(.NREQ(NREQ), .addr_width(AW), .data_width(DW)) bus ();

    regfile_write_arbiter #(
        .NREQ(NREQ), .addr_width(AW), .data_width(DW), .lo(LO), .hi(HI), .INIT_VALUE(INITV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (bus),
        .WE        (WE),
        .ADDR_IN   (ADDR_IN),
        .D_IN      (D_IN),
        .GRANT     (GRANT),
        .INIT_DONE (INIT_DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic [NREQ-1:0] g;
        bit              e;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;

    // Reference model state
    bit m_init;
    int m_cnt;
    int m_ptr;
    int m_win;

    logic [NREQ-1:0] drv_v;
    logic [AW-1:0]   drv_a [NREQ];
    logic [DW-1:0]   drv_d [NREQ];
    bit              pend  [NREQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: called at a negedge, drives inputs, checks READY/INIT_DONE, queues the expected write, returns at next negedge.
    task automatic step();
        exp_t            e;
        logic [NREQ-1:0] exp_rdy;
        bus.REQ_VALID = drv_v;
        for (int i = 0; i < NREQ; i++) begin
            bus.REQ_ADDR[i*AW +: AW] = drv_a[i];
            bus.REQ_DATA[i*DW +: DW] = drv_d[i];
        end
        #1;
        exp_rdy = '0;
        m_win   = -1;
        if (!m_init) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (m_ptr + k) % NREQ;
                if (m_win < 0 && drv_v[i]) m_win = i;
            end
        end
        if (m_win >= 0) exp_rdy[m_win] = 1'b1;
        chk("req_ready", 64'(bus.REQ_READY), 64'(exp_rdy));
        chk("init_done", 64'(INIT_DONE), 64'(!m_init));
        if (m_init) begin
            e.a = AW'(m_cnt);
            e.d = INITV;
            e.g = '0;
            e.e = 1'b0;
            q.push_back(e);
            if (m_cnt == HI) m_init = 1'b0;
            else m_cnt++;
        end else if (m_win >= 0) begin
            e.a = drv_a[m_win];
            e.d = drv_d[m_win];
            e.g = '0;
            e.g[m_win] = 1'b1;
            e.e = 1'b0;
`ifdef REGFILE_WARB_RANGE_CHECK_EN
            e.e = (int'(e.a) < LO) || (int'(e.a) > HI);
`endif
            q.push_back(e);
            m_ptr = (m_win + 1) % NREQ;
        end
        @(negedge CLK);
    endtask

    task automatic rand_cycle();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i]) begin
                drv_v[i] = 1'($urandom_range(1));
                drv_a[i] = AW'($urandom_range(31));
                drv_d[i] = $urandom;
                pend[i]  = drv_v[i];
            end
        end
        step();
        if (m_win >= 0) pend[m_win] = 1'b0;
    endtask

    task automatic set_idle();
        drv_v = '0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    endtask

    // Called at a negedge; asserts reset mid-cycle so the async clear is visible before any clock edge.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_we", 64'(WE), 64'(0));
        chk("rst_addr", 64'(ADDR_IN), 64'(0));
        chk("rst_data", 64'(D_IN), 64'(0));
        chk("rst_grant", 64'(GRANT), 64'(0));
        chk("rst_init_done", 64'(INIT_DONE), 64'(0));
        chk("rst_err", 64'(ERR), 64'(0));
        chk("rst_ready", 64'(bus.REQ_READY), 64'(0));
        q.delete();
        started = 1'b1;
        repeat (2) @(negedge CLK);
        RST    = 1'b0;
        m_init = 1'b1;
        m_cnt  = LO;
        m_ptr  = 0;
    endtask

    // Monitor: compares every regfile write against the queued expectation, and checks hold/idle otherwise.
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d = '0;
    exp_t          me;
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (!started || RST) begin
                last_a = '0;
                last_d = '0;
                continue;
            end
            if (WE || ERR || GRANT != '0) begin
                if (q.size() == 0) begin
                    chk("spurious_write", 64'({WE, ERR, GRANT}), 64'(0));
                end else begin
                    me = q.pop_front();
                    chk("we", 64'(WE), 64'(!me.e));
                    chk("err", 64'(ERR), 64'(me.e));
                    chk("grant", 64'(GRANT), 64'(me.e ? '0 : me.g));
                    chk("addr_in", 64'(ADDR_IN), 64'(me.e ? last_a : me.a));
                    chk("d_in", 64'(D_IN), 64'(me.e ? last_d : me.d));
                end
            end else begin
                chk("hold_addr", 64'(ADDR_IN), 64'(last_a));
                chk("hold_data", 64'(D_IN), 64'(last_d));
            end
            last_a = ADDR_IN;
            last_d = D_IN;
        end
    end

    initial begin
        drv_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            drv_a[i] = '0;
            drv_d[i] = '0;
            pend[i]  = 1'b0;
        end
        bus.REQ_VALID = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_DATA  = '0;
        m_init = 1'b1;
        m_cnt  = LO;
        m_ptr  = 0;
        m_win  = -1;

        @(negedge CLK);
        do_reset();

        // Init sweep with random request noise: READY must stay 0, writes cover LO..HI.
        while (m_init) rand_cycle();

        // All four requesters valid for 8 cycles: grants rotate 1,2,4,8,...
        drv_v = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            drv_a[i] = AW'(i + 4);
            drv_d[i] = 32'h1000_0000 + 32'(i);
        end
        repeat (8) step();

        // Only requester 2, addr 7, data A5A5A5A5.
        set_idle();
        drv_v    = 4'b0100;
        drv_a[2] = 5'd7;
        drv_d[2] = 32'hA5A5_A5A5;
        step();

        // Grant to requester 1, three idle cycles, then 0 and 3 together -> 3 wins.
        set_idle();
        drv_v    = 4'b0010;
        drv_a[1] = 5'd12;
        drv_d[1] = 32'h0000_1111;
        step();
        drv_v = '0;
        repeat (3) step();
        drv_v    = 4'b1001;
        drv_a[0] = 5'd3;
        drv_d[0] = 32'h0000_0000;
        drv_a[3] = 5'd31;
        drv_d[3] = 32'h3333_3333;
        step();
        chk("rr_winner_after_idle", 64'(m_win), 64'(3));
        drv_v = 4'b0001;
        step();

        // Address below LO: dropped with ERR under the range-check build, written as-is otherwise.
        set_idle();
        drv_v    = 4'b0001;
        drv_a[0] = 5'd0;
        drv_d[0] = 32'hBAD0_0000;
        step();
        drv_v = '0;
        step();

        set_idle();
        repeat (300) rand_cycle();

        // Reset during RUN, then again mid-sweep at address 10.
        do_reset();
        while (m_cnt <= 10) rand_cycle();
        chk("sweep_addr_before_reset", 64'(ADDR_IN), 64'(10));
        do_reset();
        while (m_init) rand_cycle();
        repeat (60) rand_cycle();

        set_idle();
        repeat (3) step();
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
